// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg
//   Shared definitions for the ALU share arbiter: ALU function codes as
//   understood by the ALU, arbiter FSM state encodings and a small helper.
//   No ports (package).
package alu_share_arbiter_pkg;

  localparam logic [5:0] ALUFUNC_ADD = 6'b000000;
  localparam logic [5:0] ALUFUNC_SUB = 6'b000001;
  localparam logic [5:0] ALUFUNC_AND = 6'b011000;
  localparam logic [5:0] ALUFUNC_OR  = 6'b011110;
  localparam logic [5:0] ALUFUNC_XOR = 6'b010110;
  localparam logic [5:0] ALUFUNC_NOR = 6'b010001;
  localparam logic [5:0] ALUFUNC_A   = 6'b011010;
  localparam logic [5:0] ALUFUNC_SLL = 6'b100000;
  localparam logic [5:0] ALUFUNC_SRL = 6'b100001;
  localparam logic [5:0] ALUFUNC_SRA = 6'b100011;
  localparam logic [5:0] ALUFUNC_EQ  = 6'b110011;
  localparam logic [5:0] ALUFUNC_NEQ = 6'b110001;
  localparam logic [5:0] ALUFUNC_LT  = 6'b110101;
  localparam logic [5:0] ALUFUNC_LEZ = 6'b111101;
  localparam logic [5:0] ALUFUNC_GEZ = 6'b111001;
  localparam logic [5:0] ALUFUNC_GTZ = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// alu_share_arbiter_rr_arbiter2
//   Two-way grant: round-robin (FIXED_PRIO=0) or port-0-wins (FIXED_PRIO=1).
//   A lone request always wins. The round-robin pointer moves only when upd
//   is high, i.e. when the grant was actually taken.
// Ports
//   clk, reset   clock, asynchronous active-high reset
//   req [1:0]    per-port request
//   upd          grant accepted this cycle; advance pointer
//   grant [1:0]  combinational one-hot (or zero) grant
module alu_share_arbiter_rr_arbiter2 #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] grant
);

  // 1: port 1 is preferred on the next tie (port 0 was granted last)
  logic prefer1;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ((FIXED_PRIO == 0) && prefer1) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prefer1 <= 1'b0;
    end else if (upd && (FIXED_PRIO == 0)) begin
      prefer1 <= grant[0];
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters. The winning request's
//   operands are latched into an operand register that drives the ALU; the
//   result is captured after one EXEC cycle and held on the owner's response
//   port until accepted. One operation in flight at a time.
//
//   state | meaning
//   IDLE  | no operation; accept a new request
//   EXEC  | operand register drives ALU; capture alu_s at end of cycle
//   RESP  | result held for owner; on handshake may accept the next request
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   req_valid/req_ready     per-port request handshake (ready one-hot or zero)
//   req_a/req_b             per-port operands, port 0 in the low DW bits
//   req_signed, req_func    per-port signed flag and 6-bit function code
//   resp_valid/resp_ready   per-port response handshake
//   resp_s                  registered result shared by both ports
//   alu_a/b/signed/func     registered ALU operands
//   alu_s                   ALU result (combinational from alu_*)
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned DW         = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [2*DW-1:0] req_a,
  input  logic [2*DW-1:0] req_b,
  input  logic [1:0]      req_signed,
  input  logic [11:0]     req_func,
  output logic [1:0]      resp_valid,
  input  logic [1:0]      resp_ready,
  output logic [DW-1:0]   resp_s,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic            alu_signed,
  output logic [5:0]      alu_func,
  input  logic [DW-1:0]   alu_s
);

  state_t     state;
  logic       owner;
  logic [1:0] grant;
  logic       can_accept;
  logic       accept;
  logic       win;

  alu_share_arbiter_rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .upd   (accept),
    .grant (grant)
  );

  // A new request may be taken in IDLE or in the cycle the owner drains RESP.
  // reset gates ready so nothing is offered while state is being cleared.
  assign can_accept = (state == ST_IDLE) || ((state == ST_RESP) && resp_ready[owner]);
  assign req_ready  = (can_accept && !reset) ? grant : 2'b00;
  assign accept     = |req_ready;
  assign win        = req_ready[1];
  assign resp_valid = (state == ST_RESP) ? port_onehot(owner) : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_signed <= 1'b0;
      alu_func   <= ALUFUNC_ADD;
      resp_s     <= '0;
    end else begin
      if (accept) begin
        owner      <= win;
        alu_a      <= win ? req_a[2*DW-1:DW] : req_a[DW-1:0];
        alu_b      <= win ? req_b[2*DW-1:DW] : req_b[DW-1:0];
        alu_signed <= win ? req_signed[1] : req_signed[0];
        alu_func   <= win ? req_func[11:6] : req_func[5:0];
      end
      case (state)
        ST_IDLE: begin
          if (accept) state <= ST_EXEC;
        end
        ST_EXEC: begin
          resp_s <= alu_s;
          state  <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready[owner]) state <= accept ? ST_EXEC : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Two arbiter instances (round-robin and fixed priority) share one set of
//   request/response inputs; sel_fp picks whose outputs are observed. Each
//   instance drives its own behavioural ALU. Expected grants and responses are
//   queued by the tests and consumed by a negedge monitor.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int DW = 32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [5:0]  f;
  } op_t;

  typedef struct {
    int          port;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      req_valid = '0;
  logic [1:0]      req_signed = '0;
  logic [1:0]      resp_ready = '0;
  logic [2*DW-1:0] req_a = '0;
  logic [2*DW-1:0] req_b = '0;
  logic [11:0]     req_func = '0;

  logic [1:0]  rr_req_ready, rr_resp_valid, fp_req_ready, fp_resp_valid;
  logic [31:0] rr_resp_s, rr_alu_a, rr_alu_b, rr_alu_s;
  logic [31:0] fp_resp_s, fp_alu_a, fp_alu_b, fp_alu_s;
  logic        rr_alu_signed, fp_alu_signed;
  logic [5:0]  rr_alu_func, fp_alu_func;

  logic        sel_fp = 1'b0;
  logic [1:0]  m_req_ready, m_resp_valid;
  logic [31:0] m_resp_s, m_alu_a, m_alu_b;
  logic        m_alu_signed;
  logic [5:0]  m_alu_func;

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn, input logic [5:0] f);
    logic lt;
    lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
    case (f)
      ALUFUNC_ADD: return a + b;
      ALUFUNC_SUB: return a - b;
      ALUFUNC_AND: return a & b;
      ALUFUNC_OR:  return a | b;
      ALUFUNC_XOR: return a ^ b;
      ALUFUNC_NOR: return ~(a | b);
      ALUFUNC_A:   return a;
      ALUFUNC_SLL: return a << b[4:0];
      ALUFUNC_SRL: return a >> b[4:0];
      ALUFUNC_SRA: return 32'($signed(a) >>> b[4:0]);
      ALUFUNC_EQ:  return {31'b0, a == b};
      ALUFUNC_NEQ: return {31'b0, a != b};
      ALUFUNC_LT:  return {31'b0, lt};
      ALUFUNC_LEZ: return {31'b0, $signed(a) <= 0};
      ALUFUNC_GEZ: return {31'b0, $signed(a) >= 0};
      ALUFUNC_GTZ: return {31'b0, $signed(a) > 0};
      default:     return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign rr_alu_s = alu_model(rr_alu_a, rr_alu_b, rr_alu_signed, rr_alu_func);
  assign fp_alu_s = alu_model(fp_alu_a, fp_alu_b, fp_alu_signed, fp_alu_func);

  alu_share_arbiter #(.FIXED_PRIO(0), .DW(DW)) dut (
    .clk (clk), .reset (reset),
    .req_valid (req_valid), .req_ready (rr_req_ready),
    .req_a (req_a), .req_b (req_b), .req_signed (req_signed), .req_func (req_func),
    .resp_valid (rr_resp_valid), .resp_ready (resp_ready), .resp_s (rr_resp_s),
    .alu_a (rr_alu_a), .alu_b (rr_alu_b), .alu_signed (rr_alu_signed),
    .alu_func (rr_alu_func), .alu_s (rr_alu_s)
  );

  alu_share_arbiter #(.FIXED_PRIO(1), .DW(DW)) dut_fp (
    .clk (clk), .reset (reset),
    .req_valid (req_valid), .req_ready (fp_req_ready),
    .req_a (req_a), .req_b (req_b), .req_signed (req_signed), .req_func (req_func),
    .resp_valid (fp_resp_valid), .resp_ready (resp_ready), .resp_s (fp_resp_s),
    .alu_a (fp_alu_a), .alu_b (fp_alu_b), .alu_signed (fp_alu_signed),
    .alu_func (fp_alu_func), .alu_s (fp_alu_s)
  );

  assign m_req_ready  = sel_fp ? fp_req_ready  : rr_req_ready;
  assign m_resp_valid = sel_fp ? fp_resp_valid : rr_resp_valid;
  assign m_resp_s     = sel_fp ? fp_resp_s     : rr_resp_s;
  assign m_alu_a      = sel_fp ? fp_alu_a      : rr_alu_a;
  assign m_alu_b      = sel_fp ? fp_alu_b      : rr_alu_b;
  assign m_alu_signed = sel_fp ? fp_alu_signed : rr_alu_signed;
  assign m_alu_func   = sel_fp ? fp_alu_func   : rr_alu_func;

  int   checks = 0;
  int   failures = 0;
  op_t  q0[$];
  op_t  q1[$];
  exp_t exp_resp[$];
  int   exp_grant[$];
  logic [1:0] acc = '0;
  logic rst_evt = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=none required=event", name);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] p_a = '0, p_b = '0;
  logic        p_sgn = 1'b0;
  logic [5:0]  p_f = '0;
  logic        p_acc = 1'b0;

  always @(posedge reset) rst_evt = 1'b1;

  always @(negedge clk) begin
    if (!reset) begin
      chk("req_ready_onehot0", {31'b0, $onehot0(m_req_ready)}, 32'd1);
      chk("resp_valid_onehot0", {31'b0, $onehot0(m_resp_valid)}, 32'd1);
      if (!p_acc && !rst_evt) begin
        chk("alu_a_stable", m_alu_a, p_a);
        chk("alu_b_stable", m_alu_b, p_b);
        chk("alu_signed_stable", {31'b0, m_alu_signed}, {31'b0, p_sgn});
        chk("alu_func_stable", {26'b0, m_alu_func}, {26'b0, p_f});
      end
      if ((req_valid & m_req_ready) != 2'b00) begin
        if (exp_grant.size() == 0) fail_now("unexpected_grant");
        else chk("grant_port", {31'b0, m_req_ready[1]}, 32'(exp_grant.pop_front()));
      end
      if (m_resp_valid != 2'b00) begin
        if (exp_resp.size() == 0) fail_now("unexpected_resp");
        else begin
          chk("resp_port", {31'b0, m_resp_valid[1]}, 32'(exp_resp[0].port));
          chk("resp_s", m_resp_s, exp_resp[0].val);
          if (resp_ready[m_resp_valid[1]]) exp_resp.delete(0);
        end
      end
    end
    acc     = reset ? 2'b00 : (req_valid & m_req_ready);
    p_acc   = |acc;
    p_a     = m_alu_a;
    p_b     = m_alu_b;
    p_sgn   = m_alu_signed;
    p_f     = m_alu_func;
    rst_evt = reset;
  end

  // ---------------- request driver ----------------
  always @(posedge clk) begin
    #1;
    if (acc[0] && q0.size() > 0) q0.delete(0);
    if (acc[1] && q1.size() > 0) q1.delete(0);
    req_valid[0] = (q0.size() != 0);
    req_valid[1] = (q1.size() != 0);
    if (q0.size() != 0) begin
      req_a[31:0] = q0[0].a; req_b[31:0] = q0[0].b;
      req_signed[0] = q0[0].sgn; req_func[5:0] = q0[0].f;
    end
    if (q1.size() != 0) begin
      req_a[63:32] = q1[0].a; req_b[63:32] = q1[0].b;
      req_signed[1] = q1[0].sgn; req_func[11:6] = q1[0].f;
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int port, input logic [5:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic sgn, input logic [31:0] expv);
    op_t  o;
    exp_t e;
    o.a = a; o.b = b; o.sgn = sgn; o.f = f;
    e.port = port; e.val = expv;
    if (port == 0) q0.push_back(o);
    else q1.push_back(o);
    exp_resp.push_back(e);
  endtask

  task automatic do_reset(input logic fp);
    step();
    reset = 1'b1;
    q0.delete(); q1.delete();
    exp_resp.delete(); exp_grant.delete();
    resp_ready = 2'b00;
    sel_fp = fp;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic wait_sig(input logic resp, input int port, input string name);
    int   n;
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 50) begin
      @(negedge clk);
      n++;
      hit = resp ? m_resp_valid[port] : m_req_ready[port];
    end
    chk({name, "_seen"}, {31'b0, hit}, 32'd1);
  endtask

  task automatic count_to_resp(input int port, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_resp_valid[port] && n < 20);
  endtask

  task automatic wait_drain(input string name);
    int left;
    for (int i = 0; i < 100; i++) begin
      left = q0.size() + q1.size() + exp_resp.size() + exp_grant.size();
      if (left == 0) break;
      @(negedge clk);
    end
    left = q0.size() + q1.size() + exp_resp.size() + exp_grant.size();
    chk({name, "_drain"}, 32'(left), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- tests ----------------
  initial begin
    int lat;

    // reset state
    #3;
    chk("rst_req_ready", {30'b0, m_req_ready}, 32'd0);
    chk("rst_resp_valid", {30'b0, m_resp_valid}, 32'd0);
    chk("rst_resp_s", m_resp_s, 32'd0);
    chk("rst_alu_a", m_alu_a, 32'd0);
    chk("rst_alu_func", {26'b0, m_alu_func}, {26'b0, ALUFUNC_ADD});

    // 1: single op, latency, hold while owner not ready (non-owner ready ignored)
    do_reset(1'b0);
    resp_ready = 2'b10;
    push(0, ALUFUNC_ADD, 32'd5, 32'd3, 1'b0, 32'd8);
    exp_grant.push_back(0);
    wait_sig(1'b0, 0, "t1_req");
    count_to_resp(0, lat);
    chk("t1_latency", 32'(lat), 32'd2);
    step();
    push(1, ALUFUNC_NOR, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF);
    exp_grant.push_back(1);
    repeat (3) begin
      @(negedge clk);
      chk("t1_hold_req_ready", {30'b0, m_req_ready}, 32'd0);
      chk("t1_hold_resp_valid", {30'b0, m_resp_valid}, 32'd1);
    end
    step();
    resp_ready = 2'b11;
    wait_drain("t1");

    // 2: round-robin, both valid every cycle
    do_reset(1'b0);
    resp_ready = 2'b11;
    push(0, ALUFUNC_LT,  32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1);
    push(1, ALUFUNC_SUB, 32'd10, 32'd4, 1'b0, 32'd6);
    push(0, ALUFUNC_ADD, 32'd1, 32'd2, 1'b0, 32'd3);
    push(1, ALUFUNC_XOR, 32'hF0, 32'hFF, 1'b0, 32'h0F);
    exp_grant = '{0, 1, 0, 1};
    wait_drain("t2");

    // 3: fixed priority, same traffic
    do_reset(1'b1);
    resp_ready = 2'b11;
    push(0, ALUFUNC_LT,  32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1);
    push(0, ALUFUNC_ADD, 32'd1, 32'd2, 1'b0, 32'd3);
    push(1, ALUFUNC_SUB, 32'd10, 32'd4, 1'b0, 32'd6);
    push(1, ALUFUNC_XOR, 32'hF0, 32'hFF, 1'b0, 32'h0F);
    exp_grant = '{0, 0, 1, 1};
    wait_drain("t3");

    // 4: RESP handshake and new accept in the same cycle
    do_reset(1'b0);
    resp_ready = 2'b11;
    push(0, ALUFUNC_OR,  32'h0F00, 32'h00F0, 1'b0, 32'h0FF0);
    push(1, ALUFUNC_SLL, 32'd1, 32'd31, 1'b0, 32'h8000_0000);
    push(0, ALUFUNC_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0, 32'h0F00_0F00);
    exp_grant = '{0, 1, 0};
    wait_sig(1'b1, 0, "t4_resp0");
    chk("t4_accept_in_resp", {30'b0, m_req_ready}, 32'd2);
    count_to_resp(1, lat);
    chk("t4_gap1", 32'(lat), 32'd2);
    chk("t4_accept_in_resp2", {30'b0, m_req_ready}, 32'd1);
    count_to_resp(0, lat);
    chk("t4_gap2", 32'(lat), 32'd2);
    wait_drain("t4");

    // 5: reset during EXEC, reset during RESP, then a clean op
    do_reset(1'b0);
    resp_ready = 2'b00;
    push(0, ALUFUNC_ADD, 32'd1, 32'd1, 1'b0, 32'd2);
    push(1, ALUFUNC_A, 32'h1234, 32'd0, 1'b0, 32'h1234);
    exp_resp.delete(0);
    exp_grant = '{0, 1};
    wait_sig(1'b0, 0, "t5_req0");
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5_exec_req_ready", {30'b0, m_req_ready}, 32'd0);
    chk("t5_exec_resp_valid", {30'b0, m_resp_valid}, 32'd0);
    chk("t5_exec_alu_a", m_alu_a, 32'd0);
    #1 reset = 1'b0;
    wait_sig(1'b1, 1, "t5_resp1");
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t5_resp_resp_valid", {30'b0, m_resp_valid}, 32'd0);
    chk("t5_resp_resp_s", m_resp_s, 32'd0);
    #1 reset = 1'b0;
    exp_resp.delete();
    chk("t5_grants_used", 32'(exp_grant.size()), 32'd0);
    resp_ready = 2'b11;
    push(0, ALUFUNC_SRA, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000);
    exp_grant.push_back(0);
    wait_drain("t5");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
